// File: rtl/program_prefetch_if.sv
// Bundles the prefetch stage's memory-side Avalon-MM read port, the redirect
// request and the core-side valid/ready instruction stream.
//   master : the prefetch stage (drives memory requests and the instruction stream)
//   slave  : the environment (program memory, redirect source and consuming core)
interface program_prefetch_if #(
  parameter int unsigned ADDR_W = 14
);
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_write;
  logic [3:0]        mem_byteenable;
  logic [31:0]       mem_writedata;
  logic              mem_clken;
  logic [31:0]       mem_readdata;
  logic              flush;
  logic [ADDR_W-1:0] flush_addr;
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr_data;
  logic [ADDR_W-1:0] instr_addr;

  modport master (
    output mem_address, mem_chipselect, mem_write, mem_byteenable,
           mem_writedata, mem_clken, instr_valid, instr_data, instr_addr,
    input  mem_readdata, flush, flush_addr, instr_ready
  );

  modport slave (
    input  mem_address, mem_chipselect, mem_write, mem_byteenable,
           mem_writedata, mem_clken, instr_valid, instr_data, instr_addr,
    output mem_readdata, flush, flush_addr, instr_ready
  );
endinterface

// File: rtl/program_prefetch.sv
// Instruction prefetch stage. Issues sequential word reads to the program
// memory, absorbs the one-cycle read latency in a DEPTH-entry FIFO and streams
// {data, addr} to the core over valid/ready. A flush redirects fetch to
// flush_addr and discards everything buffered or in flight.
// Ports:
//   clk     : clock
//   reset_n : synchronous active-low reset
//   bus     : program_prefetch_if.master (memory read port, flush, instr stream)
module program_prefetch #(
  parameter int unsigned       ADDR_W     = 14,
  parameter int unsigned       DEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input logic                clk,
  input logic                reset_n,
  program_prefetch_if.master bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_REDIR = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] inflight_addr;
  logic [ADDR_W-1:0] addr_q;
  logic              inflight;
  logic [31:0]       fifo_data [DEPTH];
  logic [ADDR_W-1:0] fifo_addr [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  logic              pop;
  logic              push;
  logic              issue;
  logic [OCC_W-1:0]  occ;
  logic [OCC_W-1:0]  limit;

  // Issue decision: a slot is reserved for every word buffered or in flight,
  // counting a same-cycle pop as freeing one.
  always_comb begin
    pop   = (count != '0) && bus.instr_ready;
    push  = inflight && !bus.flush;
    occ   = OCC_W'(count) + OCC_W'(inflight);
    limit = OCC_W'(DEPTH) + OCC_W'(pop);
    issue = (state != ST_INIT) && !bus.flush && (occ < limit);
  end

  // Memory request: address follows pc on issue, otherwise holds the last one.
  assign bus.mem_chipselect = issue;
  assign bus.mem_address    = issue ? pc : addr_q;
  assign bus.mem_write      = 1'b0;
  assign bus.mem_byteenable = 4'hF;
  assign bus.mem_writedata  = 32'h0;
  assign bus.mem_clken      = 1'b1;

  // Instruction stream is the FIFO head; it only moves on a transfer.
  assign bus.instr_valid = (count != '0);
  assign bus.instr_data  = fifo_data[head];
  assign bus.instr_addr  = fifo_addr[head];

  // FSM, fetch pointer, in-flight tracking and FIFO; flush wins over all else.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= ST_INIT;
      pc            <= RESET_ADDR;
      inflight      <= 1'b0;
      inflight_addr <= '0;
      addr_q        <= '0;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_data[PTR_W'(i)] <= '0;
        fifo_addr[PTR_W'(i)] <= '0;
      end
    end else begin
      case (state)
        ST_INIT:  state <= ST_FETCH;
        ST_FETCH: state <= bus.flush ? ST_REDIR : ST_FETCH;
        ST_REDIR: state <= bus.flush ? ST_REDIR : ST_FETCH;
        default:  state <= ST_INIT;
      endcase

      if (bus.flush) begin
        pc       <= bus.flush_addr;
        inflight <= 1'b0;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
      end else begin
        inflight <= issue;
        if (issue) begin
          pc            <= ADDR_W'(pc + 1'b1);
          inflight_addr <= pc;
          addr_q        <= pc;
        end
        if (push) begin
          fifo_data[tail] <= bus.mem_readdata;
          fifo_addr[tail] <= inflight_addr;
          tail            <= PTR_W'(tail + 1'b1);
        end
        if (pop) begin
          head <= PTR_W'(head + 1'b1);
        end
        if (push && !pop) begin
          count <= CNT_W'(count + 1'b1);
        end else if (!push && pop) begin
          count <= CNT_W'(count - 1'b1);
        end
      end
    end
  end

endmodule

// File: tb/tb_program_prefetch.sv
module tb_program_prefetch;
  localparam int unsigned ADDR_W = 14;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  program_prefetch_if #(.ADDR_W(ADDR_W)) bus();

  program_prefetch #(
    .ADDR_W(ADDR_W),
    .DEPTH(4),
    .RESET_ADDR('0)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  // Program memory: synchronous read, one cycle latency.
  logic [31:0] mem [1 << ADDR_W];
  always @(posedge clk) begin
    if (bus.mem_chipselect) bus.mem_readdata <= mem[bus.mem_address];
  end

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] exp_data(input logic [ADDR_W-1:0] a);
    return 32'hA000_0000 + 32'(a);
  endfunction

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    bus.flush = 1'b0;
    next_cyc();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.instr_ready = 1'b1;
    bus.flush = 1'b0;
    bus.flush_addr = '0;
    reset_n = 1'b0;
    next_cyc();
    next_cyc();
    @(negedge clk);
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.instr_data !== 32'h0 || bus.instr_addr !== 14'h0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b data=%h addr=%h expected 0/0/0",
               bus.instr_valid, bus.instr_data, bus.instr_addr);
    end
    checks++;
    if (bus.mem_chipselect !== 1'b0 || bus.mem_address !== 14'h0) begin
      errors++;
      $display("FAIL reset_mem: got cs=%b addr=%h expected 0/0", bus.mem_chipselect, bus.mem_address);
    end
    checks++;
    if (bus.mem_write !== 1'b0 || bus.mem_byteenable !== 4'hF ||
        bus.mem_writedata !== 32'h0 || bus.mem_clken !== 1'b1) begin
      errors++;
      $display("FAIL tied_outputs: got we=%b be=%h wd=%h clken=%b expected 0/f/0/1",
               bus.mem_write, bus.mem_byteenable, bus.mem_writedata, bus.mem_clken);
    end
    next_cyc();
    reset_n = 1'b1;
    // cycle 0: INIT, no issue
    @(negedge clk);
    checks++;
    if (bus.mem_chipselect !== 1'b0) begin
      errors++;
      $display("FAIL init_no_issue: got cs=%b expected 0", bus.mem_chipselect);
    end
    next_cyc();
    // cycle 1: RESET_ADDR issues
    @(negedge clk);
    checks++;
    if (bus.mem_chipselect !== 1'b1 || bus.mem_address !== 14'h0) begin
      errors++;
      $display("FAIL first_issue: got cs=%b addr=%h expected 1/0000", bus.mem_chipselect, bus.mem_address);
    end
    next_cyc();
    @(negedge clk);
    checks++;
    if (bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL cycle2_valid: got %b expected 0", bus.instr_valid);
    end
    next_cyc();
    // cycle 3: first word valid
    @(negedge clk);
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr_addr !== 14'h0 || bus.instr_data !== 32'hA000_0000) begin
      errors++;
      $display("FAIL first_word: got valid=%b addr=%h data=%h expected 1/0000/a0000000",
               bus.instr_valid, bus.instr_addr, bus.instr_data);
    end
    next_cyc();
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr_addr !== ADDR_W'(i) || bus.instr_data !== 32'hA000_0000 + 32'(i)) begin
        errors++;
        $display("FAIL stream[%0d]: got valid=%b addr=%h data=%h expected 1/%h/%h",
                 i, bus.instr_valid, bus.instr_addr, bus.instr_data, ADDR_W'(i), 32'hA000_0000 + 32'(i));
      end
      next_cyc();
    end
  endtask

  task automatic test_stall();
    int issues;
    issues = 0;
    bus.instr_ready = 1'b0;
    apply_reset();
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      if (bus.mem_chipselect === 1'b1) issues++;
      if (c == 12) begin
        checks++;
        if (bus.mem_chipselect !== 1'b0 || bus.instr_valid !== 1'b1 || bus.instr_addr !== 14'h0) begin
          errors++;
          $display("FAIL stall_full: got cs=%b valid=%b addr=%h expected 0/1/0000",
                   bus.mem_chipselect, bus.instr_valid, bus.instr_addr);
        end
      end
      next_cyc();
    end
    checks++;
    if (issues != 4) begin
      errors++;
      $display("FAIL stall_issue_count: got %0d expected 4", issues);
    end
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr_addr !== ADDR_W'(i) || bus.instr_data !== 32'hA000_0000 + 32'(i)) begin
        errors++;
        $display("FAIL stall_release[%0d]: got valid=%b addr=%h data=%h expected 1/%h",
                 i, bus.instr_valid, bus.instr_addr, bus.instr_data, ADDR_W'(i));
      end
      next_cyc();
    end
  endtask

  task automatic test_flush();
    bus.instr_ready = 1'b0;
    apply_reset();
    for (int c = 0; c < 5; c++) next_cyc();
    // cycle 5: three words buffered, one in flight; flush with a pop attempt
    bus.flush = 1'b1;
    bus.flush_addr = 14'h0100;
    bus.instr_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.mem_chipselect !== 1'b0 || bus.instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL flush_cycle: got cs=%b valid=%b expected 0/1", bus.mem_chipselect, bus.instr_valid);
    end
    next_cyc();
    bus.flush = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.mem_chipselect !== 1'b1 || bus.mem_address !== 14'h0100) begin
      errors++;
      $display("FAIL flush_t1: got valid=%b cs=%b addr=%h expected 0/1/0100",
               bus.instr_valid, bus.mem_chipselect, bus.mem_address);
    end
    next_cyc();
    @(negedge clk);
    checks++;
    if (bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_t2: got valid=%b expected 0", bus.instr_valid);
    end
    next_cyc();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr_addr !== 14'h0100 + ADDR_W'(i) ||
          bus.instr_data !== exp_data(14'h0100 + ADDR_W'(i))) begin
        errors++;
        $display("FAIL flush_word[%0d]: got valid=%b addr=%h data=%h expected 1/%h",
                 i, bus.instr_valid, bus.instr_addr, bus.instr_data, 14'h0100 + ADDR_W'(i));
      end
      next_cyc();
    end
  endtask

  task automatic test_back_to_back();
    bus.instr_ready = 1'b1;
    bus.flush = 1'b1;
    bus.flush_addr = 14'h0010;
    next_cyc();
    bus.flush_addr = 14'h0020;
    @(negedge clk);
    checks++;
    if (bus.mem_chipselect !== 1'b0 || bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_flush: got cs=%b valid=%b expected 0/0", bus.mem_chipselect, bus.instr_valid);
    end
    next_cyc();
    bus.flush = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mem_chipselect !== 1'b1 || bus.mem_address !== 14'h0020 || bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_issue: got cs=%b addr=%h valid=%b expected 1/0020/0",
               bus.mem_chipselect, bus.mem_address, bus.instr_valid);
    end
    next_cyc();
    @(negedge clk);
    checks++;
    if (bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: got valid=%b expected 0", bus.instr_valid);
    end
    next_cyc();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr_addr !== 14'h0020 + ADDR_W'(i) ||
          bus.instr_data !== exp_data(14'h0020 + ADDR_W'(i))) begin
        errors++;
        $display("FAIL b2b_word[%0d]: got valid=%b addr=%h data=%h expected 1/%h",
                 i, bus.instr_valid, bus.instr_addr, bus.instr_data, 14'h0020 + ADDR_W'(i));
      end
      next_cyc();
    end
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] exp_a;
    bus.instr_ready = 1'b1;
    bus.flush = 1'b1;
    bus.flush_addr = 14'h3FFE;
    next_cyc();
    bus.flush = 1'b0;
    next_cyc();
    next_cyc();
    exp_a = 14'h3FFE;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr_addr !== exp_a || bus.instr_data !== exp_data(exp_a)) begin
        errors++;
        $display("FAIL wrap[%0d]: got valid=%b addr=%h data=%h expected 1/%h/%h",
                 i, bus.instr_valid, bus.instr_addr, bus.instr_data, exp_a, exp_data(exp_a));
      end
      exp_a = ADDR_W'(exp_a + 1'b1);
      next_cyc();
    end
  endtask

  task automatic test_reset_random();
    logic [ADDR_W-1:0] exp_a;
    logic [ADDR_W-1:0] prev_addr;
    logic [31:0]       prev_data;
    logic              hold;
    int                xfers;
    bus.flush = 1'b0;
    apply_reset();
    exp_a = '0;
    hold = 1'b0;
    prev_addr = '0;
    prev_data = '0;
    xfers = 0;
    for (int c = 0; c < 10000; c++) begin
      bus.instr_ready = 1'($urandom_range(0, 1));
      reset_n = (c != 5000);
      @(negedge clk);
      if (hold && bus.instr_valid === 1'b1) begin
        checks++;
        if (bus.instr_addr !== prev_addr || bus.instr_data !== prev_data) begin
          errors++;
          $display("FAIL rnd_stable c=%0d: got addr=%h data=%h expected %h/%h",
                   c, bus.instr_addr, bus.instr_data, prev_addr, prev_data);
        end
      end
      if (c == 5001) begin
        checks++;
        if (bus.instr_valid !== 1'b0) begin
          errors++;
          $display("FAIL rnd_after_reset: got valid=%b expected 0", bus.instr_valid);
        end
      end
      if (reset_n && bus.instr_valid === 1'b1 && bus.instr_ready) begin
        checks++;
        if (bus.instr_addr !== exp_a || bus.instr_data !== exp_data(exp_a)) begin
          errors++;
          $display("FAIL rnd_xfer c=%0d: got addr=%h data=%h expected %h/%h",
                   c, bus.instr_addr, bus.instr_data, exp_a, exp_data(exp_a));
        end
        exp_a = ADDR_W'(exp_a + 1'b1);
        xfers++;
      end
      hold = reset_n && (bus.instr_valid === 1'b1) && !bus.instr_ready;
      prev_addr = bus.instr_addr;
      prev_data = bus.instr_data;
      if (!reset_n) begin
        exp_a = '0;
        hold = 1'b0;
      end
      next_cyc();
    end
    reset_n = 1'b1;
    checks++;
    if (xfers < 2000) begin
      errors++;
      $display("FAIL rnd_progress: got %0d transfers expected at least 2000", xfers);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'hA000_0000 + 32'(i);
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_back_to_back();
    test_wrap();
    test_reset_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_prefetch.md
# program_prefetch

Instruction prefetch stage that sits directly downstream of the program memory: it acts as the read-only master on the memory's Avalon-MM port and streams 32-bit instruction words to the processor core through a valid/ready interface. It issues sequential word reads, absorbs the memory's fixed one-cycle read latency in a small FIFO, and supports a redirect (flush) to an arbitrary word address for branches and exceptions.

## Interface
- ADDR_W, 14: word-address width; matches the 16384-word program memory.
- DEPTH, 4: prefetch FIFO depth in words; power of two, at least 2.
- RESET_ADDR, 0: first word address fetched after reset.

- clk  in  1  single clock for all logic.
- reset_n  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- mem_address  out  ADDR_W  word address presented to the program memory.
- mem_chipselect  out  1  high in each cycle a read is issued.
- mem_write  out  1  tied 0.
- mem_byteenable  out  4  tied 4'hF.
- mem_writedata  out  32  tied 0.
- mem_clken  out  1  tied 1.
- mem_readdata  in  32  memory data; valid exactly one cycle after the issue cycle.
- flush  in  1  redirect request; one-cycle pulse or level, acted on in every cycle it is high.
- flush_addr  in  ADDR_W  new fetch word address; sampled when flush is high.
- instr_valid  out  1  instr_data/instr_addr hold a valid word.
- instr_ready  in  1  core accepts the word; a transfer occurs when instr_valid and instr_ready are both high.
- instr_data  out  32  instruction word.
- instr_addr  out  ADDR_W  word address of instr_data.

## Operation
- Registers: fetch pointer pc (ADDR_W), inflight flag, inflight address, FIFO of DEPTH entries {data, addr}, and count (0..DEPTH).
- Issue rule: a read of pc issues (mem_chipselect=1, mem_address=pc) when the FSM is in FETCH, flush is low, and count + inflight - pop < DEPTH, where pop = instr_valid & instr_ready. On issue: pc <= pc+1 (modulo 2^ADDR_W, so 0x3FFF wraps to 0x0000), inflight <= 1, inflight address <= pc. Otherwise inflight <= 0.
- Capture: when inflight=1 and there is no flush in the current cycle, {mem_readdata, inflight address} is written to the FIFO tail.
- Pop: FIFO head leaves on a transfer. A push and a pop in the same cycle leave count unchanged.
- When mem_chipselect=0, mem_address holds its last value.
- FSM states: INIT (first cycle after reset), FETCH (normal operation), REDIR (one cycle after a flush).
  - INIT -> FETCH unconditionally; no issue in INIT.
  - FETCH -> REDIR when flush=1.
  - REDIR -> FETCH unconditionally unless flush=1 again, in which case it stays in REDIR; issues follow the FETCH rule in REDIR.
- Flush (cycle t): FIFO emptied (count <= 0), inflight <= 0 with any response due in t+1 dropped, pc <= flush_addr. No issue in cycle t. A pop in cycle t is ignored, and instr_valid is forced to 0 in t+1.
- Flush takes priority over push, pop and issue in the same cycle. A later flush overrides an earlier one.

## Timing
- Reset values: instr_valid=0, instr_data=0, instr_addr=0, mem_chipselect=0, mem_address=0, count=0, inflight=0, pc=RESET_ADDR, state=INIT.
- Latency: a read issued in cycle n is captured at the end of n+1. instr_valid is high in n+2, so issue-to-valid latency is 2 cycles.
- First fetch: with reset_n released before edge 0, the FSM is in INIT in cycle 0, RESET_ADDR issues in cycle 1, and instr_valid rises in cycle 3.
- Redirect penalty: with flush in cycle t, flush_addr issues in t+1 and its word is valid in t+3.
- Throughput: with instr_ready held high, one word per cycle is sustained.
- Stall: with instr_ready low, at most DEPTH words are held. Issue stops when count + inflight = DEPTH, so no word is lost or duplicated.
- instr_data and instr_addr are stable while instr_valid=1 and instr_ready=0.
- Reset asserted mid-operation discards everything in the next cycle and restarts from RESET_ADDR.

## Test plan
- Reset release, instr_ready=1, memory preloaded with mem[i]=0xA000_0000+i -> valid from cycle 3. Addresses 0,1,2,... appear on consecutive cycles with data 0xA0000000, 0xA0000001, ...
- instr_ready=0 for 10 cycles after the first word -> exactly 4 words buffered, mem_chipselect low once full. Releasing ready yields 0..3 with no gap, and then 4 onward.
- flush with flush_addr=0x0100 while 3 words are buffered -> next transfer is addr 0x0100 with data mem[0x100], 3 cycles after the flush. No stale word is delivered.
- Back-to-back flushes to 0x0010 then 0x0020 -> the first word delivered is 0x0020. Nothing from 0x0010 appears.
- flush_addr=0x3FFE -> addresses 0x3FFE, 0x3FFF, 0x0000, 0x0001 delivered in order.
- reset_n low for 1 cycle mid-stream with ready toggling randomly -> instr_valid is 0 next cycle and the stream restarts at RESET_ADDR. The scoreboard confirms no drops or duplicates across 10k random-ready cycles.
